t08_mem_responder: RTL

- Memory-side responder for the t08 core's memory handler: accepts read / write / instruction-fetch requests and drives busy, read data and done back to it.
- Decodes each request to one of two targets: the Wishbone-style data bus (SRAM and peripherals) or the I2C sample register at I2C_ADDR.
- Generates byte lanes and shifts write/read data so the handler always sees the addressed byte or half in bits [7:0] / [15:0].

---
 rtl/t08_mem_responder_pkg.sv | 29 ++
 rtl/t08_mem_responder_if.sv | 21 ++
 rtl/t08_mem_responder_lane_align.sv | 31 +++
 rtl/t08_mem_responder.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/t08_mem_responder_pkg.sv
// Shared types and constants for the t08 memory responder.
// Optional bus timeout is enabled with the T08_BUS_TIMEOUT_EN macro (see top).
package t08_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUS,
    ST_I2C_WAIT,
    ST_RESP
  } state_e;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam logic [31:0] I2C_ADDR_DEF = 32'd923923;
  localparam logic [31:0] ERR_DATA     = 32'hDEAD_BEEF;

  function automatic logic is_byte(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_BU);
  endfunction

  function automatic logic is_half(input logic [2:0] f3);
    return (f3 == F3_H) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/t08_mem_responder_if.sv
// Wishbone-style data bus between the responder (master) and SRAM/peripherals.
interface t08_mem_responder_if;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
    output wb_dat_i, wb_ack_i
  );
endinterface

// File: rtl/t08_mem_responder_lane_align.sv
// Byte-lane generator: select mask, write/read lane shifts and misalign flag.
module t08_lane_align
  import t08_mem_pkg::*;
(
  input  logic [2:0]  func3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  sel_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o
);

  always_comb begin
    sel_o      = 4'b1111;
    misalign_o = (off_i != 2'd0);
    if (is_byte(func3_i)) begin
      sel_o      = 4'b0001 << off_i;
      misalign_o = 1'b0;
    end else if (is_half(func3_i)) begin
      sel_o      = 4'b0011 << off_i;
      misalign_o = off_i[0];
    end
  end

  // Upper read bits are passed through untouched; the handler sign/zero-extends.
  assign wdata_o = wdata_i << {off_i, 3'b000};
  assign rdata_o = rdata_i >> {off_i, 3'b000};

endmodule

// File: rtl/t08_mem_responder.sv
// Memory responder for the t08 handler: routes requests to the data bus or the
// I2C sample register. Define T08_BUS_TIMEOUT_EN to abort stalled bus cycles.
module t08_mem_responder
  import t08_mem_pkg::*;
#(
  parameter logic [31:0] I2C_ADDR = I2C_ADDR_DEF
`ifdef T08_BUS_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 64
`endif
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       read_i,
  input  logic                       write_i,
  input  logic                       fetch_i,
  input  logic [2:0]                 func3_i,
  input  logic [31:0]                addr_i,
  input  logic [31:0]                wdata_i,
  output logic [31:0]                rdata_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_o,
  t08_mem_responder_if.master        wb,
  input  logic [31:0]                i2c_data_i,
  input  logic                       i2c_valid_i,
  output logic                       i2c_ack_o
);

  state_e      state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] addr_q;
  logic        we_q;
  logic [3:0]  sel_q;
  logic [31:0] wdat_q;
  logic        lat_en;
  logic        i2c_ack;

  logic        can_accept, req_any, req_we, req_i2c;
  logic [2:0]  req_f3;
  logic [1:0]  lane_off;
  logic [3:0]  lane_sel;
  logic [31:0] lane_wdat, lane_rdat;
  logic        lane_mis;
  logic        in_bus;
  logic        expired;

  assign in_bus     = (state_q == ST_BUS);
  assign can_accept = (state_q == ST_IDLE) || (state_q == ST_RESP);
  assign req_any    = write_i | read_i | fetch_i;
  assign req_we     = write_i;
  assign req_f3     = (write_i | read_i) ? func3_i : F3_W;
  assign req_i2c    = (addr_i == I2C_ADDR);

  // One aligner serves both directions: no request is accepted while in BUS,
  // so the offset can switch to the latched address for the read shift.
  assign lane_off = in_bus ? addr_q[1:0] : addr_i[1:0];

  t08_lane_align u_lane (
    .func3_i    (req_f3),
    .off_i      (lane_off),
    .wdata_i    (wdata_i),
    .rdata_i    (wb.wb_dat_i),
    .sel_o      (lane_sel),
    .wdata_o    (lane_wdat),
    .rdata_o    (lane_rdat),
    .misalign_o (lane_mis)
  );

`ifdef T08_BUS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tmo_q, tmo_d;

  assign expired = (tmo_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_d = '0;
    if (in_bus) tmo_d = tmo_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!nrst) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`else
  assign expired = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    lat_en  = 1'b0;
    i2c_ack = 1'b0;
    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (state_q == ST_RESP) state_d = ST_IDLE;
        if (req_any) begin
          // The I2C register sits at an odd address, so it bypasses misalign checks.
          if (req_i2c) begin
            if (req_we) begin
              state_d = ST_RESP;
            end else if (i2c_valid_i) begin
              state_d = ST_RESP;
              rdata_d = i2c_data_i;
              i2c_ack = 1'b1;
            end else begin
              state_d = ST_I2C_WAIT;
            end
          end else if (lane_mis) begin
            state_d = ST_RESP;
            rdata_d = '0;
            err_d   = 1'b1;
          end else begin
            state_d = ST_BUS;
            lat_en  = 1'b1;
          end
        end
      end
      ST_BUS: begin
        if (wb.wb_ack_i) begin
          state_d = ST_RESP;
          if (!we_q) rdata_d = lane_rdat;
        end else if (expired) begin
          state_d = ST_RESP;
          rdata_d = ERR_DATA;
          err_d   = 1'b1;
        end
      end
      ST_I2C_WAIT: begin
        if (i2c_valid_i) begin
          state_d = ST_RESP;
          rdata_d = i2c_data_i;
          i2c_ack = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
      rdata_q <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      wdat_q  <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (lat_en) begin
        addr_q <= addr_i;
        we_q   <= req_we;
        sel_q  <= lane_sel;
        wdat_q <= lane_wdat;
      end
    end
  end

  assign rdata_o   = rdata_q;
  assign busy_o    = in_bus || (state_q == ST_I2C_WAIT);
  assign done_o    = (state_q == ST_RESP);
  assign err_o     = err_q;
  assign i2c_ack_o = nrst && i2c_ack;

  assign wb.wb_cyc_o = in_bus;
  assign wb.wb_stb_o = in_bus;
  assign wb.wb_we_o  = in_bus && we_q;
  assign wb.wb_sel_o = in_bus ? sel_q : 4'b0000;
  assign wb.wb_adr_o = in_bus ? {addr_q[31:2], 2'b00} : 32'd0;
  assign wb.wb_dat_o = in_bus ? wdat_q : 32'd0;

endmodule
